// File: rtl/comp_thresh_serial_loader.sv
// comp_thresh_serial_loader: latches per-channel threshold words and shifts them MSB-first to DACs over SCLK/SDATA with per-channel CS_B
module comp_thresh_serial_loader #(
  parameter int NBITS   = 16,
  parameter int NCHAN   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [NCHAN-1:0]       CHAN_MASK,
  input  logic [NCHAN*NBITS-1:0] DATA,
  output logic                   SCLK,
  output logic                   SDATA,
  output logic [NCHAN-1:0]       CS_B,
  output logic                   BUSY,
  output logic                   DONE
);
  localparam int BW = NBITS > 1 ? $clog2(NBITS) : 1;
  localparam int CW = NCHAN > 1 ? $clog2(NCHAN) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SHIFT_LO, S_SHIFT_HI, S_DESELECT, S_DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] ch, ch_d, first_mask, first_pend;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0] cnt, cnt_d;
  logic [NCHAN*NBITS-1:0] data_q, data_d;
  logic [NCHAN-1:0] pend, pend_d, cs_d;
  logic [NBITS-1:0] word;
  logic sclk_d, sdata_d, busy_d, done_d, last, clr;
  function automatic logic [CW-1:0] lowest(input logic [NCHAN-1:0] m);
    lowest = '0;
    for (int i = NCHAN - 1; i >= 0; i--) if (m[i]) lowest = CW'(i);
  endfunction
  // state and output registers; all outputs come straight from flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      ch     <= '0;
      bit_q  <= '0;
      cnt    <= '0;
      data_q <= '0;
      pend   <= '0;
      SCLK   <= 1'b0;
      SDATA  <= 1'b0;
      CS_B   <= '1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_d;
      ch     <= ch_d;
      bit_q  <= bit_d;
      cnt    <= cnt_d;
      data_q <= data_d;
      pend   <= pend_d;
      SCLK   <= sclk_d;
      SDATA  <= sdata_d;
      CS_B   <= cs_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
    end
  end
  // next-state and next-output logic; pend holds enabled channels not yet shifted
  always_comb begin
    state_d    = state;
    ch_d       = ch;
    bit_d      = bit_q;
    cnt_d      = cnt;
    data_d     = data_q;
    pend_d     = pend;
    sclk_d     = SCLK;
    sdata_d    = SDATA;
    cs_d       = CS_B;
    busy_d     = BUSY;
    done_d     = DONE;
    clr        = ABORT && state != S_IDLE;
    last       = cnt == 8'(CLK_DIV - 1);
    word       = data_q[ch*NBITS +: NBITS];
    first_mask = lowest(CHAN_MASK);
    first_pend = lowest(pend);
    case (state)
      S_IDLE: if (START && !ABORT) begin
        data_d = DATA;
        cnt_d  = '0;
        if (CHAN_MASK == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SELECT;
          busy_d  = 1'b1;
          ch_d    = first_mask;
          pend_d  = CHAN_MASK & ~(NCHAN'(1) << first_mask);
          cs_d    = ~(NCHAN'(1) << first_mask);
        end
      end
      S_SELECT: begin
        cnt_d = last ? '0 : cnt + 8'd1;
        if (last) begin
          state_d = S_SHIFT_LO;
          bit_d   = BW'(NBITS - 1);
          sdata_d = word[NBITS-1];
        end
      end
      S_SHIFT_LO: begin
        cnt_d = last ? '0 : cnt + 8'd1;
        if (last) begin
          state_d = S_SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end
      S_SHIFT_HI: begin
        cnt_d = last ? '0 : cnt + 8'd1;
        if (last) begin
          sclk_d = 1'b0;
          if (bit_q != '0) begin
            state_d = S_SHIFT_LO;
            bit_d   = bit_q - BW'(1);
            sdata_d = word[bit_q-BW'(1)];
          end else begin
            state_d = S_DESELECT;
            cs_d    = '1;
            sdata_d = 1'b0;
          end
        end
      end
      S_DESELECT: begin
        cnt_d = last ? '0 : cnt + 8'd1;
        if (last && pend != '0) begin
          state_d = S_SELECT;
          ch_d    = first_pend;
          pend_d  = pend & ~(NCHAN'(1) << first_pend);
          cs_d    = ~(NCHAN'(1) << first_pend);
        end else if (last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: if (!START) begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: clr = 1'b1;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      ch_d    = '0;
      bit_d   = '0;
      cnt_d   = '0;
      pend_d  = '0;
      sclk_d  = 1'b0;
      sdata_d = 1'b0;
      cs_d    = '1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end
endmodule

// File: tb/tb_comp_thresh_serial_loader.sv
// tb_comp_thresh_serial_loader: randomized loads on two configurations checked against a transaction-level model
module tb_comp_thresh_serial_loader;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic start_a = 0, abort_a = 0, start_b = 0, abort_b = 0;
  logic [3:0] mask_a = '0, cs_a;
  logic [63:0] data_a = '0;
  logic [1:0] mask_b = '0, cs_bb;
  logic [23:0] data_b = '0;
  logic sclk_a, sdata_a, busy_a, done_a, sclk_b, sdata_b, busy_b, done_b;
  int cyc = 0, errors = 0, checks = 0;
  int done_t, multi, stray, act, pulses, fall_t;
  logic [31:0] cur;
  logic p_sclk = 0, p_done = 0;
  logic [15:0] p_cs = '1;
  int q_ch[$], q_pul[$], q_fall[$], q_rise[$];
  logic [31:0] q_word[$];
  comp_thresh_serial_loader dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .ABORT(abort_a), .CHAN_MASK(mask_a), .DATA(data_a),
    .SCLK(sclk_a), .SDATA(sdata_a), .CS_B(cs_a), .BUSY(busy_a), .DONE(done_a));
  comp_thresh_serial_loader #(.NBITS(12), .NCHAN(2), .CLK_DIV(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .ABORT(abort_b), .CHAN_MASK(mask_b), .DATA(data_b),
    .SCLK(sclk_b), .SDATA(sdata_b), .CS_B(cs_bb), .BUSY(busy_b), .DONE(done_b));
  wire m_sclk = sel ? sclk_b : sclk_a;
  wire m_sdata = sel ? sdata_b : sdata_a;
  wire m_busy = sel ? busy_b : busy_a;
  wire m_done = sel ? done_b : done_a;
  wire [15:0] m_cs = sel ? {14'h3fff, cs_bb} : {12'hfff, cs_a};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // transaction monitor: one record per chip-select window
  always @(negedge clk) begin
    if (m_sclk && !p_sclk) begin
      cur = {cur[30:0], m_sdata};
      pulses++;
    end
    if (!(&m_cs) && (&p_cs)) begin
      fall_t = cyc;
      cur = '0;
      pulses = 0;
      for (int i = 0; i < 16; i++) if (!m_cs[i]) act = i;
    end
    if ((&m_cs) && !(&p_cs)) begin
      q_ch.push_back(act);
      q_word.push_back(cur);
      q_pul.push_back(pulses);
      q_fall.push_back(fall_t);
      q_rise.push_back(cyc);
    end
    if ($countones(~m_cs) > 1) multi++;
    if (m_sclk && (&m_cs)) stray++;
    if (m_done && !p_done) done_t = cyc;
    p_sclk = m_sclk;
    p_cs = m_cs;
    p_done = m_done;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_load(input logic s, input logic [63:0] d, input logic [3:0] m, input logic mutate);
    int nb, nc, cd, p, n, k, t, e0;
    logic [63:0] w;
    nb = s ? 12 : 16;
    nc = s ? 2 : 4;
    cd = s ? 1 : 2;
    p = cd * (2 * nb + 2);
    n = 0;
    for (int c = 0; c < nc; c++) if (m[c]) n++;
    @(negedge clk);
    sel = s;
    q_ch.delete(); q_word.delete(); q_pul.delete(); q_fall.delete(); q_rise.delete();
    done_t = -1; multi = 0; stray = 0;
    if (s) begin
      data_b = d[23:0]; mask_b = m[1:0]; start_b = 1;
    end else begin
      data_a = d; mask_a = m; start_a = 1;
    end
    e0 = cyc + 1;
    @(negedge clk);
    if (n > 0) check("busy_e0", m_busy, 1);
    check("done_e0", m_done, n == 0);
    if (mutate) begin
      data_a = ~data_a; data_b = ~data_b; mask_a = ~mask_a; mask_b = ~mask_b;
    end
    t = 0;
    while (!m_done && t < n * p + 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    check("done_time", done_t - e0, n * p);
    check("busy_done", m_busy, 0);
    check("nrec", q_ch.size(), n);
    k = 0;
    for (int c = 0; c < nc; c++) if (m[c] && k < q_ch.size()) begin
      w = (d >> (c * nb)) & ((64'd1 << nb) - 1);
      check("chan", q_ch[k], c);
      check("word", q_word[k], w);
      check("pulses", q_pul[k], nb);
      check("cs_fall", q_fall[k] - e0, k * p);
      check("cs_rise", q_rise[k] - q_fall[k], cd * (2 * nb + 1));
      k++;
    end
    check("multi_cs", multi, 0);
    check("stray_sclk", stray, 0);
    repeat (10) @(negedge clk);
    check("no_retrig", q_ch.size(), n);
    check("done_hold", m_done, 1);
    start_a = 0; start_b = 0;
    @(negedge clk);
    check("done_clr", m_done, 0);
  endtask
  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check("rst_cs_a", cs_a, 4'hf);
    check("rst_cs_b", cs_bb, 2'h3);
    check("rst_out_a", {sclk_a, sdata_a, busy_a, done_a}, 0);
    check("rst_out_b", {sclk_b, sdata_b, busy_b, done_b}, 0);
    rst_n = 1;
    run_load(0, 64'hA5A5_0001_FFFF_8000, 4'hf, 0);
    run_load(0, 64'hA5A5_0001_FFFF_8000, 4'b0100, 0);
    run_load(0, {$urandom, $urandom}, 4'h0, 0);
    // abort mid-load
    @(negedge clk);
    data_a = {$urandom, $urandom}; mask_a = 4'hf; start_a = 1; e0 = cyc + 1;
    while (cyc < e0 + 99) @(negedge clk);
    abort_a = 1;
    @(negedge clk);
    check("abort_cs", cs_a, 4'hf);
    check("abort_out", {sclk_a, sdata_a, busy_a, done_a}, 0);
    abort_a = 0; start_a = 0;
    @(negedge clk);
    run_load(0, {$urandom, $urandom}, 4'hf, 0);
    // asynchronous reset mid-load
    @(negedge clk);
    data_a = {$urandom, $urandom}; mask_a = 4'hf; start_a = 1; e0 = cyc + 1;
    while (cyc < e0 + 30) @(negedge clk);
    check("pre_rst_cs", cs_a, 4'he);
    #1 rst_n = 0;
    #1;
    check("arst_cs", cs_a, 4'hf);
    check("arst_out", {sclk_a, sdata_a, busy_a, done_a}, 0);
    @(negedge clk);
    rst_n = 1; start_a = 0;
    @(negedge clk);
    run_load(0, {$urandom, $urandom}, 4'hf, 0);
    // ABORT held in IDLE blocks a start
    @(negedge clk);
    abort_a = 1; start_a = 1; mask_a = 4'hf;
    repeat (3) @(negedge clk);
    check("abort_idle_busy", busy_a, 0);
    check("abort_idle_cs", cs_a, 4'hf);
    abort_a = 0; start_a = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_load(0, {$urandom, $urandom}, 4'($urandom_range(15)), i[0]);
    run_load(1, 64'h0000_0000_00AB_C123, 4'h3, 1);
    for (int i = 0; i < 4; i++) run_load(1, {32'h0, $urandom}, 4'($urandom_range(3)), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
